// File: rtl/bit_table_ctrl.sv
// Front-end controller for a DEPTH x 1 bit masked SRAM macro: reset/flush sweep, read/write arbitration,
// 1-cycle read response with same-cycle write forwarding. Define BIT_TABLE_FLUSH_EN to enable flush.
module bit_table_ctrl #(
  parameter int   DEPTH    = 256,
  parameter int   ADDR_W   = 8,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              resp_valid,
  output logic              resp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              init_done,
  output logic              R0_clk,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic              R0_data,
  output logic              W0_clk,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic              W0_data,
  output logic              W0_mask
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_pend;
  logic              r_fwd_hit;
  logic              r_fwd_data;
  logic              w_flush;
  logic              w_sweep_last;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_resp_valid;

`ifdef BIT_TABLE_FLUSH_EN
  assign w_flush = flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_flush        = 1'b0;
`endif

  assign w_sweep_last = (r_cnt == ADDR_W'(DEPTH - 1));
  assign w_rd_acc     = rd_valid & rd_ready;
  assign w_wr_acc     = wr_valid & wr_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (w_flush) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
          if (w_sweep_last) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_flush) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are gated by reset so the reset-state values hold during the reset cycle itself.
  always_comb begin
    rd_ready  = 1'b0;
    wr_ready  = 1'b0;
    init_done = 1'b0;
    R0_en     = 1'b0;
    R0_addr   = '0;
    W0_en     = 1'b0;
    W0_addr   = '0;
    W0_data   = 1'b0;
    if (!reset) begin
      if (r_state == ST_INIT) begin
        W0_en   = 1'b1;
        W0_addr = r_cnt;
        W0_data = INIT_VAL;
      end else begin
        rd_ready  = 1'b1;
        wr_ready  = 1'b1;
        init_done = 1'b1;
        R0_en     = rd_valid;
        R0_addr   = rd_addr;
        W0_en     = wr_valid;
        W0_addr   = wr_addr;
        W0_data   = wr_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_rd_acc;
      // The macro's read-during-write result is not trusted; a same-address write overrides it.
      r_fwd_hit  <= w_rd_acc & w_wr_acc & (rd_addr == wr_addr);
      r_fwd_data <= wr_data;
    end
  end

  assign w_resp_valid = r_pend & ~reset;
  assign resp_valid   = w_resp_valid;
  assign resp_data    = w_resp_valid & (r_fwd_hit ? r_fwd_data : R0_data);

  assign R0_clk  = clock;
  assign W0_clk  = clock;
  assign W0_mask = 1'b1;

endmodule

// File: tb/tb_bit_table_ctrl.sv
// Self-checking bench for bit_table_ctrl: sweep checks, vector table, randomized traffic against a table model.
module tb_bit_table_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          resp_valid;
  logic          resp_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          wr_ready;
  logic          flush;
  logic          init_done;
  logic          R0_clk;
  logic [AW-1:0] R0_addr;
  logic          R0_en;
  logic          R0_data;
  logic          W0_clk;
  logic [AW-1:0] W0_addr;
  logic          W0_en;
  logic          W0_data;
  logic          W0_mask;

  always #5 clock = ~clock;

  bit_table_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .INIT_VAL(1'b0)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .init_done(init_done),
    .R0_clk(R0_clk), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_clk(W0_clk), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  // Macro model: synchronous read returning the pre-write contents on a collision, no reset.
  logic mem [DEPTH];
  logic r0q;
  always @(posedge R0_clk) if (R0_en) r0q <= mem[R0_addr];
  always @(posedge W0_clk) if (W0_en && W0_mask) mem[W0_addr] <= W0_data;
  assign R0_data = r0q;

  int total = 0;
  int bad   = 0;
  bit ref_mem [DEPTH];

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AW-1:0] wa;
    logic          wd;
    logic          erv;
    logic          erd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic sweep(input int flush_at, input int reset_at, input logic [1:0] first_resp, output int ncyc);
    int cnt;
    bit done;
    cnt  = 0;
    done = 1'b0;
    ncyc = 0;
    while (!done && ncyc < 4 * DEPTH) begin
      if (ncyc == reset_at) begin
        reset = 1'b1;
        @(negedge clock);
        chk("sweep_rst", 32'({W0_en, rd_ready, init_done, R0_en, resp_valid, resp_data}), 32'(0));
        next_cyc();
        reset = 1'b0;
        cnt   = 0;
      end else begin
        flush = (ncyc == flush_at);
        @(negedge clock);
        chk("sweep", 32'({W0_en, W0_addr, W0_data, W0_mask, rd_ready, wr_ready, init_done, R0_en}),
            32'({1'b1, cnt[AW-1:0], 1'b0, 1'b1, 4'b0000}));
        chk("sweep_resp", 32'({resp_valid, resp_data}), 32'((ncyc == 0) ? first_resp : 2'b00));
        next_cyc();
        flush = 1'b0;
        if (ncyc == flush_at) cnt = 0;
        else if (cnt == DEPTH - 1) done = 1'b1;
        else cnt++;
      end
      ncyc++;
    end
    chk("sweep_done", 32'(done), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  nz;
    bit  pend;
    bit  pd;

    tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    foreach (mem[i]) mem[i] = 1'($urandom_range(0, 1));
    r0q = 1'b0;

    // Reset held with client requests asserted: nothing may be accepted or written.
    reset = 1'b1; rd_valid = 1'b1; rd_addr = 8'h7F;
    wr_valid = 1'b1; wr_addr = 8'h03; wr_data = 1'b1; flush = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("reset_state", 32'({rd_ready, wr_ready, init_done, resp_valid, resp_data, R0_en, W0_en}), 32'(0));
      next_cyc();
    end
    reset = 1'b0;
    wr_valid = 1'b0;

    sweep(-1, -1, 2'b00, n);
    chk("sweep_len", 32'(n), 32'(DEPTH));
    nz = 0;
    foreach (mem[i]) if (mem[i] !== 1'b0) nz++;
    chk("mem_init", 32'(nz), 32'(0));
    foreach (ref_mem[i]) ref_mem[i] = 1'b0;

    @(negedge clock);
    chk("run_ready", 32'({init_done, rd_ready, wr_ready, R0_en, R0_addr}), 32'({4'b1111, 8'h7F}));
    chk("run_noresp", 32'(resp_valid), 32'(0));
    next_cyc();
    rd_valid = 1'b0;
    @(negedge clock);
    chk("rd7f", 32'({resp_valid, resp_data}), 32'(2'b10));
    next_cyc();

    for (int i = 0; i < 13; i++) begin
      rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      @(negedge clock);
      chk($sformatf("vec%0d", i), 32'({resp_valid, resp_data}), 32'({tbl[i].erv, tbl[i].erd}));
      chk($sformatf("vec%0d_rdy", i), 32'({rd_ready, wr_ready, R0_en, W0_en}),
          32'({2'b11, tbl[i].rv, tbl[i].wv}));
      if (tbl[i].wv) ref_mem[tbl[i].wa] = tbl[i].wd;
      next_cyc();
    end

    // Randomized traffic: a read returns the table contents including any same-cycle write.
    pend = 1'b0;
    pd   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd_valid = 1'($urandom_range(0, 1)); rd_addr = raddr();
      wr_valid = 1'($urandom_range(0, 1)); wr_addr = raddr();
      wr_data  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) wr_addr = rd_addr;
      @(negedge clock);
      chk("rand_resp", 32'({resp_valid, resp_data}), 32'({pend, pend & pd}));
      if (rd_valid) pd = (wr_valid && wr_addr == rd_addr) ? wr_data : ref_mem[rd_addr];
      pend = rd_valid;
      if (wr_valid) ref_mem[wr_addr] = wr_data;
      next_cyc();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clock);
    chk("rand_drain", 32'({resp_valid, resp_data}), 32'({pend, pend & pd}));
    next_cyc();

    wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 1'b1;
    @(negedge clock);
    chk("set05", 32'({wr_ready, W0_en}), 32'(2'b11));
    next_cyc();
    ref_mem[5] = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h05; flush = 1'b1;
    @(negedge clock);
    chk("flush_rd_acc", 32'({rd_ready, R0_en}), 32'(2'b11));
    next_cyc();
    flush = 1'b0;
    rd_valid = 1'b0;
`ifdef BIT_TABLE_FLUSH_EN
    sweep(-1, -1, 2'b11, n);
    chk("flush_len", 32'(n), 32'(DEPTH));
    foreach (ref_mem[i]) ref_mem[i] = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h05;
    @(negedge clock);
    chk("flush_run", 32'({init_done, R0_en}), 32'(2'b11));
    next_cyc();
    flush = 1'b1;
    @(negedge clock);
    chk("rd05_after_flush", 32'({resp_valid, resp_data}), 32'(2'b10));
    next_cyc();
    flush = 1'b0;
    sweep(100, -1, 2'b10, n);
    chk("flush_restart_len", 32'(n), 32'(101 + DEPTH));
    @(negedge clock);
    chk("flush2_run", 32'({init_done, R0_en, R0_addr}), 32'({2'b11, 8'h05}));
    next_cyc();
    rd_valid = 1'b0;
    @(negedge clock);
    chk("flush2_resp", 32'({resp_valid, resp_data}), 32'(2'b10));
    next_cyc();
`else
    @(negedge clock);
    chk("noflush_run", 32'({init_done, rd_ready, W0_en}), 32'(3'b110));
    chk("noflush_resp", 32'({resp_valid, resp_data}), 32'(2'b11));
    next_cyc();
`endif

    // Reset one cycle after an accepted read: the response is dropped and the sweep restarts.
    rd_valid = 1'b1; rd_addr = 8'h22;
    @(negedge clock);
    chk("pre_rst_rd", 32'(R0_en), 32'(1));
    next_cyc();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_drop", 32'({resp_valid, resp_data, rd_ready, init_done, W0_en}), 32'(0));
    next_cyc();
    reset = 1'b0;
    sweep(-1, 50, 2'b00, n);
    chk("rst50_len", 32'(n), 32'(51 + DEPTH));
    @(negedge clock);
    chk("rst50_run", 32'({init_done, R0_en, R0_addr, resp_valid}), 32'({2'b11, 8'h22, 1'b0}));
    next_cyc();
    rd_valid = 1'b0;
    @(negedge clock);
    chk("rst50_resp", 32'({resp_valid, resp_data}), 32'(2'b10));
    next_cyc();
    @(negedge clock);
    chk("rst50_idle", 32'({resp_valid, resp_data}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_table_ctrl.md
# bit_table_ctrl

Front-end controller for a 256 x 1 bit masked predictor-metadata SRAM macro, such as a useful-bit or confidence-bit table. It sits directly upstream of the macro and drives its R0/W0 ports. After reset or flush it sweeps every entry to a known value, because the macro has no reset. It then arbitrates client read/write requests, returns read data one cycle later with same-cycle write forwarding, and hides macro read-during-write semantics from clients.

## Interface
- DEPTH, 256, number of entries; must be a power of two.
- ADDR_W, 8, log2(DEPTH).
- INIT_VAL, 1'b0, value written to every entry during a sweep.
- clock  in  1  single clock for the controller and both macro ports.
- reset  in  1  synchronous, active-high.
- rd_valid  in  1  client read request.
- rd_addr  in  ADDR_W  read address.
- rd_ready  out  1  read accepted this cycle (high only in RUN).
- resp_valid  out  1  read data valid.
- resp_data  out  1  read data.
- wr_valid  in  1  client write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  1  write data.
- wr_ready  out  1  write accepted this cycle (high only in RUN).
- flush  in  1  pulse: re-initialise the whole table.
- init_done  out  1  high while in RUN.
- R0_clk, W0_clk  out  1  both driven from clock.
- R0_addr  out  ADDR_W; R0_en  out  1; R0_data  in  1.
- W0_addr  out  ADDR_W; W0_en  out  1; W0_data  out  1; W0_mask  out  1, driven 1 on every write.

## Operation
- FSM has two states: INIT and RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - Each cycle: W0_en=1, W0_addr=counter, W0_data=INIT_VAL, then counter+1.
  - After the write to DEPTH-1 (counter wrap), go to RUN.
  - rd_ready, wr_ready, init_done = 0; R0_en = 0; client requests are not accepted and the client must hold them.
- RUN:
  - rd_ready = wr_ready = init_done = 1.
  - Read accept (rd_valid): R0_en=1, R0_addr=rd_addr; record addr and "pending".
  - Write accept (wr_valid): W0_en=1, W0_addr=wr_addr, W0_data=wr_data.
  - Read and write may both be accepted in one cycle, to any addresses.
- Forwarding:
  - If a read and a write are accepted in the same cycle to the same address, resp_data = that wr_data, not R0_data.
  - A write accepted in the cycle after the read does not affect that response.
- flush (only when FLUSH_EN is defined):
  - Asserted in RUN: enter INIT with counter = 0 next cycle. Any read accepted in that same cycle still returns its response.
  - Asserted in INIT: restart the counter at 0.
- Reset mid-sweep or mid-read: back to INIT at 0; no response is issued for the in-flight read.

## Timing
- Reset values: resp_valid=0, resp_data=0, rd_ready=0, wr_ready=0, init_done=0, R0_en=0, W0_en=0; counter=0.
- First W0_en=1 occurs in the first cycle after reset deasserts.
- Sweep lasts exactly DEPTH cycles; init_done rises in cycle DEPTH after reset release.
- Read latency is 1 cycle: a read accepted in cycle t gives resp_valid=1 in t+1 for exactly one cycle.
- resp_data is registered-forward or R0_data (combinational) in t+1. resp_data returns to 0 when resp_valid=0.
- Back-to-back reads give one response per cycle.
- Writes are visible to reads accepted in the cycle after the write, or later, in the same cycle only via forwarding.

## Configuration
- BIT_TABLE_FLUSH_EN defined: flush behaves as above.
- BIT_TABLE_FLUSH_EN undefined: the flush port exists but is ignored. INIT is entered only via reset, and no flush logic is synthesised.

## Test plan
- Reset release -> W0_en high for 256 consecutive cycles at addresses 0..255 with data 0; init_done rises in cycle 256; a read of address 0x7F then returns resp_data=0 at t+1.
- Write 0x10=1 in cycle t, read 0x10 in t+1 -> resp_valid=1, resp_data=1 in t+2.
- Read and write of 0x22 with data 1 in the same cycle (stored value 0) -> resp_data=1 next cycle; a later read returns 1.
- Read 0x33 (stored 1) in t and write 0x33=0 in t+1 -> response in t+1 is 1.
- With BIT_TABLE_FLUSH_EN: set 0x05=1, pulse flush -> rd_ready=0 for 256 cycles, then a read of 0x05 returns 0. Flush pulsed at sweep count 100 -> sweep restarts at 0, 256 more cycles.
- Assert reset at sweep count 50 with rd_valid held -> counter restarts at 0, no resp_valid until 1 cycle after the first post-init accepted read.
